// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated transmit FIFO.
//
// A producer pushes words with a valid/ready handshake. Whenever the
// serialiser is idle and the FIFO holds a word, the word is popped and sent
// as a frame: a start bit, DATA_BITS data bits LSB first, an optional parity
// bit, then STOP_BITS stop bits. Every bit lasts CLK_DIV clk cycles.
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, the parity_odd input is added and every frame carries a
//   parity bit: XOR of the data bits, inverted when parity_odd is 1.
//   parity_odd is sampled when the word is popped.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   parity_odd in   odd-parity select (UART_TX_PARITY_EN builds only)
//   wr_data    in   word to transmit (DATA_BITS)
//   wr_valid   in   producer offers wr_data
//   wr_ready   out  FIFO not full (combinational)
//   txd        out  serial line, idles high (registered)
//   busy       out  frame in progress or FIFO non-empty
//   fifo_count out  number of occupied FIFO entries
//   overflow   out  sticky: a write was offered while the FIFO was full
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 868,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int STOP_CYC = STOP_BITS * CLK_DIV;
  localparam int BW       = $clog2(STOP_CYC + 1);
  localparam int IW       = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BIT_LOAD  = BW'(CLK_DIV - 1);
  // The last stop cycle is spent in IDLE so the next frame can start right
  // after it; STOP itself therefore covers STOP_CYC-1 cycles.
  localparam logic [BW-1:0] STOP_LOAD = BW'(STOP_CYC - 2);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_t;

`ifdef UART_TX_PARITY_EN
  // Parity bit for a frame: even parity of the data, inverted for odd parity.
  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d,
                                        input logic odd);
    return (^d) ^ odd;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 overflow_r;
  logic                 push_s;
  logic                 pop_s;

  // Serialiser
  state_t               state_r, state_nx_s;
  logic [BW-1:0]        cnt_r, cnt_nx_s;
  logic [IW-1:0]        idx_r, idx_nx_s;
  logic [DATA_BITS-1:0] shift_r, shift_nx_s;
  logic                 txd_r, txd_nx_s;
  logic                 bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic                 par_r, par_nx_s;
`endif

  assign wr_ready   = (count_r != FULL_CNT);
  assign push_s     = wr_valid && wr_ready;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;
  assign txd        = txd_r;
  assign busy       = (state_r != ST_IDLE) || (count_r != {CW{1'b0}});
  assign bit_end_s  = (cnt_r == {BW{1'b0}});

  // FIFO pointers, occupancy, storage and the sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_BITS{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CW'(1);
      end else begin
        count_r <= count_r;
      end
      if (wr_valid && !wr_ready) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Serialiser state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {BW{1'b0}};
      idx_r   <= {IW{1'b0}};
      shift_r <= {DATA_BITS{1'b0}};
      txd_r   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      idx_r   <= idx_nx_s;
      shift_r <= shift_nx_s;
      txd_r   <= txd_nx_s;
`ifdef UART_TX_PARITY_EN
      par_r   <= par_nx_s;
`endif
    end
  end

  // Next-state and next-datapath logic; txd is computed one cycle ahead so
  // that the registered line changes exactly on bit boundaries.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    idx_nx_s   = idx_r;
    shift_nx_s = shift_r;
    txd_nx_s   = txd_r;
    pop_s      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nx_s   = par_r;
`endif
    case (state_r)
      ST_IDLE: begin
        txd_nx_s = 1'b1;
        if (count_r != {CW{1'b0}}) begin
          pop_s      = 1'b1;
          shift_nx_s = mem_r[rd_ptr_r];
          cnt_nx_s   = BIT_LOAD;
          idx_nx_s   = {IW{1'b0}};
          txd_nx_s   = 1'b0;
          state_nx_s = ST_START;
`ifdef UART_TX_PARITY_EN
          par_nx_s   = frame_parity(mem_r[rd_ptr_r], parity_odd);
`endif
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_nx_s = ST_DATA;
          cnt_nx_s   = BIT_LOAD;
          idx_nx_s   = {IW{1'b0}};
          txd_nx_s   = shift_r[0];
        end else begin
          cnt_nx_s   = cnt_r - BW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          if (idx_r == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_nx_s = ST_PARITY;
            cnt_nx_s   = BIT_LOAD;
            txd_nx_s   = par_r;
`else
            // A single stop cycle in total is covered by IDLE alone.
            txd_nx_s = 1'b1;
            if (STOP_CYC == 1) begin
              state_nx_s = ST_IDLE;
            end else begin
              state_nx_s = ST_STOP;
              cnt_nx_s   = STOP_LOAD;
            end
`endif
          end else begin
            shift_nx_s = shift_r >> 1;
            txd_nx_s   = shift_r[1];
            idx_nx_s   = idx_r + IW'(1);
            cnt_nx_s   = BIT_LOAD;
          end
        end else begin
          cnt_nx_s = cnt_r - BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          txd_nx_s = 1'b1;
          if (STOP_CYC == 1) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_STOP;
            cnt_nx_s   = STOP_LOAD;
          end
        end else begin
          cnt_nx_s = cnt_r - BW'(1);
        end
      end
`endif
      ST_STOP: begin
        txd_nx_s = 1'b1;
        if (bit_end_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          cnt_nx_s = cnt_r - BW'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = {BW{1'b0}};
        txd_nx_s   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. Three instances cover the frame
// shapes of interest:
//   A: 8 data bits, depth 4, 4 clk/bit, 1 stop bit (parity when compiled in)
//   B: 5 data bits, depth 2, 2 clk/bit, 1 stop bit
//   C: 8 data bits, depth 4, 1 clk/bit, 2 stop bits
// A behavioural UART receiver decodes each txd trace and the decoded words,
// frame spacings and bit-cell shapes are compared with the expected stream.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       parity_odd_a;

  logic [7:0] wr_data_a;
  logic       wr_valid_a, wr_ready_a, txd_a, busy_a, overflow_a;
  logic [2:0] fifo_count_a;
  logic [4:0] wr_data_b;
  logic       wr_valid_b, wr_ready_b, txd_b, busy_b, overflow_b;
  logic [1:0] fifo_count_b;
  logic [7:0] wr_data_c;
  logic       wr_valid_c, wr_ready_c, txd_c, busy_c, overflow_c;
  logic [2:0] fifo_count_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic trace_a[$];
  logic trace_b[$];
  logic trace_c[$];
  int   rx_words[$];
  int   rx_starts[$];
  int   rx_par[$];
  int   rx_bad;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLK_DIV(4), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(rst_n),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd_a),
`endif
    .wr_data(wr_data_a), .wr_valid(wr_valid_a), .wr_ready(wr_ready_a),
    .txd(txd_a), .busy(busy_a), .fifo_count(fifo_count_a), .overflow(overflow_a));

  uart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(2), .CLK_DIV(2), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(rst_n),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd_a),
`endif
    .wr_data(wr_data_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
    .txd(txd_b), .busy(busy_b), .fifo_count(fifo_count_b), .overflow(overflow_b));

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLK_DIV(1), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(rst_n),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd_a),
`endif
    .wr_data(wr_data_c), .wr_valid(wr_valid_c), .wr_ready(wr_ready_c),
    .txd(txd_c), .busy(busy_c), .fifo_count(fifo_count_c), .overflow(overflow_c));

  // Line capture, one sample per cycle away from the active edge
  always @(negedge clk) begin
    trace_a.push_back(txd_a);
    trace_b.push_back(txd_b);
    trace_c.push_back(txd_c);
  end

  function automatic logic tbit(input int id, input int i);
    case (id)
      0:       return trace_a[i];
      1:       return trace_b[i];
      default: return trace_c[i];
    endcase
  endfunction

  function automatic int tlen(input int id);
    case (id)
      0:       return trace_a.size();
      1:       return trace_b.size();
      default: return trace_c.size();
    endcase
  endfunction

  // Behavioural receiver: finds each start bit, requires every cycle of a
  // bit cell to hold one level and every stop cell to be high.
  task automatic decode(input int id, input int div, input int nb, input int ns, input int np);
    int   n, i, ncell, flen, w, base;
    logic b0;
    rx_words.delete(); rx_starts.delete(); rx_par.delete(); rx_bad = 0;
    n = tlen(id);
    ncell = 1 + nb + np + ns;
    flen = ncell * div;
    i = 0;
    while (i + flen <= n) begin
      if (tbit(id, i) == 1'b0) begin
        w = 0;
        for (int c = 0; c < ncell; c++) begin
          base = i + c * div;
          b0 = tbit(id, base);
          for (int k = 1; k < div; k++) if (tbit(id, base + k) !== b0) rx_bad++;
          if (c >= 1 && c <= nb && b0 === 1'b1) w = w | (1 << (c - 1));
          if (c >= 1 + nb + np && b0 !== 1'b1) rx_bad++;
        end
        if (np != 0) rx_par.push_back(int'(tbit(id, i + (1 + nb) * div)));
        rx_words.push_back(w);
        rx_starts.push_back(i);
        i += flen;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_valid_a = 1'b0; wr_valid_b = 1'b0; wr_valid_c = 1'b0;
    wr_data_a = 8'h00; wr_data_b = 5'h00; wr_data_c = 8'h00;
    parity_odd_a = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({txd_a, wr_ready_a, busy_a, overflow_a} !== 4'b1100) begin n_fail++; $display("FAIL reset_a_flags got %b want 1100", {txd_a, wr_ready_a, busy_a, overflow_a}); end
    n_checks++; if (fifo_count_a !== 3'd0) begin n_fail++; $display("FAIL reset_a_count got %0d want 0", fifo_count_a); end
    n_checks++; if ({txd_b, wr_ready_b, busy_b, overflow_b, fifo_count_b} !== 6'b110000) begin n_fail++; $display("FAIL reset_b got %b want 110000", {txd_b, wr_ready_b, busy_b, overflow_b, fifo_count_b}); end
    n_checks++; if ({txd_c, wr_ready_c, busy_c, overflow_c, fifo_count_c} !== 7'b1100000) begin n_fail++; $display("FAIL reset_c got %b want 1100000", {txd_c, wr_ready_c, busy_c, overflow_c, fifo_count_c}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [7:0] d;
    logic       exp;
    d = 8'hA5;
    wr_data_a = d; wr_valid_a = 1'b1;
    @(negedge clk);
    wr_valid_a = 1'b0;
    n_checks++; if (fifo_count_a !== 3'd1 || txd_a !== 1'b1) begin n_fail++; $display("FAIL single_after_write got cnt=%0d txd=%b want cnt=1 txd=1", fifo_count_a, txd_a); end
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (t < 4) exp = 1'b0;
      else if (t < 36) exp = d[(t - 4) / 4];
      else exp = 1'b1;
      n_checks++; if (txd_a !== exp) begin n_fail++; $display("FAIL single_txd cycle %0d got %b want %b", t, txd_a, exp); end
      if (t == 0) begin
        n_checks++; if (fifo_count_a !== 3'd0 || busy_a !== 1'b1) begin n_fail++; $display("FAIL single_pop got cnt=%0d busy=%b want cnt=0 busy=1", fifo_count_a, busy_a); end
      end
      if (t == 38) begin
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_stop got %b want 1", busy_a); end
      end
    end
    @(negedge clk);
    n_checks++; if (busy_a !== 1'b0 || txd_a !== 1'b1) begin n_fail++; $display("FAIL single_end got busy=%b txd=%b want busy=0 txd=1", busy_a, txd_a); end
  endtask

  task automatic test_fill_full();
    int acc, popped, exp_cnt, guard;
    trace_a.delete();
    for (int w = 1; w <= 6; w++) begin
      wr_data_a = 8'(w); wr_valid_a = 1'b1;
      @(negedge clk);
      acc     = (w < 5) ? w : 5;
      popped  = (w >= 2) ? 1 : 0;
      exp_cnt = acc - popped;
      n_checks++; if (int'(fifo_count_a) !== exp_cnt) begin n_fail++; $display("FAIL fill_count w=%0d got %0d want %0d", w, fifo_count_a, exp_cnt); end
      n_checks++; if (wr_ready_a !== (exp_cnt != 4)) begin n_fail++; $display("FAIL fill_ready w=%0d got %b want %b", w, wr_ready_a, exp_cnt != 4); end
      n_checks++; if (overflow_a !== (w == 6)) begin n_fail++; $display("FAIL fill_overflow w=%0d got %b want %b", w, overflow_a, w == 6); end
    end
    wr_valid_a = 1'b0;
    guard = 0;
    while (busy_a !== 1'b0 && guard < 400) begin @(negedge clk); guard++; end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL fill_timeout busy got %b want 0", busy_a); end
    repeat (3) @(negedge clk);
    decode(0, 4, 8, 1, 0);
    n_checks++; if (rx_words.size() !== 5 || rx_bad !== 0) begin n_fail++; $display("FAIL fill_frames got %0d frames bad=%0d want 5 bad=0", rx_words.size(), rx_bad); end
    for (int k = 0; k < rx_words.size() && k < 5; k++) begin
      n_checks++; if (rx_words[k] !== k + 1) begin n_fail++; $display("FAIL fill_word %0d got %0h want %0h", k, rx_words[k], k + 1); end
      if (k > 0) begin
        n_checks++; if (rx_starts[k] - rx_starts[k-1] !== 40) begin n_fail++; $display("FAIL fill_spacing %0d got %0d want 40", k, rx_starts[k] - rx_starts[k-1]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int highs;
    wr_data_a = 8'h55; wr_valid_a = 1'b1;
    @(negedge clk); wr_data_a = 8'h11;
    @(negedge clk); wr_data_a = 8'h22;
    @(negedge clk); wr_valid_a = 1'b0;
    repeat (16) @(negedge clk);
    n_checks++; if (txd_a !== 1'b0 || fifo_count_a !== 3'd2) begin n_fail++; $display("FAIL mid_before got txd=%b cnt=%0d want txd=0 cnt=2", txd_a, fifo_count_a); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (txd_a !== 1'b1) begin n_fail++; $display("FAIL mid_txd_async got %b want 1", txd_a); end
    n_checks++; if (fifo_count_a !== 3'd0 || overflow_a !== 1'b0 || wr_ready_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_state got cnt=%0d ovf=%b rdy=%b busy=%b want 0 0 1 0", fifo_count_a, overflow_a, wr_ready_a, busy_a); end
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (txd_a === 1'b1 && busy_a === 1'b0) highs++;
    end
    n_checks++; if (highs !== 60) begin n_fail++; $display("FAIL mid_residual got %0d idle cycles want 60", highs); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int guard;
    trace_a.delete();
    parity_odd_a = 1'b0; wr_data_a = 8'h07; wr_valid_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr_valid_a = 1'b0; parity_odd_a = 1'b1;
    guard = 0;
    while (busy_a !== 1'b0 && guard < 200) begin @(negedge clk); guard++; end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL parity_timeout busy got %b want 0", busy_a); end
    repeat (3) @(negedge clk);
    parity_odd_a = 1'b0;
    decode(0, 4, 8, 1, 1);
    n_checks++; if (rx_words.size() !== 2 || rx_bad !== 0) begin n_fail++; $display("FAIL parity_frames got %0d bad=%0d want 2 bad=0", rx_words.size(), rx_bad); end
    if (rx_words.size() == 2) begin
      n_checks++; if (rx_words[0] !== 7 || rx_words[1] !== 7) begin n_fail++; $display("FAIL parity_words got %0h %0h want 7 7", rx_words[0], rx_words[1]); end
      n_checks++; if (rx_par[0] !== 1 || rx_par[1] !== 0) begin n_fail++; $display("FAIL parity_bits got %0d %0d want 1 0", rx_par[0], rx_par[1]); end
      n_checks++; if (rx_starts[1] - rx_starts[0] !== 44) begin n_fail++; $display("FAIL parity_len got %0d want 44", rx_starts[1] - rx_starts[0]); end
    end
  endtask
`endif

  task automatic test_width_wrap();
    int  next, guard;
    logic rdy;
    trace_b.delete();
    next = 0; guard = 0;
    while (next < 10 && guard < 500) begin
      wr_data_b = 5'(next); wr_valid_b = 1'b1;
      rdy = wr_ready_b;
      @(negedge clk);
      guard++;
      if (rdy) next++;
    end
    wr_valid_b = 1'b0;
    n_checks++; if (next !== 10) begin n_fail++; $display("FAIL wrap_accept got %0d want 10", next); end
    guard = 0;
    while (busy_b !== 1'b0 && guard < 400) begin @(negedge clk); guard++; end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout busy got %b want 0", busy_b); end
    repeat (3) @(negedge clk);
    decode(1, 2, 5, 1, 0);
    n_checks++; if (rx_words.size() !== 10 || rx_bad !== 0) begin n_fail++; $display("FAIL wrap_frames got %0d bad=%0d want 10 bad=0", rx_words.size(), rx_bad); end
    for (int k = 0; k < rx_words.size() && k < 10; k++) begin
      n_checks++; if (rx_words[k] !== k) begin n_fail++; $display("FAIL wrap_word %0d got %0h want %0h", k, rx_words[k], k); end
      if (k > 0) begin
        n_checks++; if (rx_starts[k] - rx_starts[k-1] !== 14) begin n_fail++; $display("FAIL wrap_spacing %0d got %0d want 14", k, rx_starts[k] - rx_starts[k-1]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int guard, highs;
    trace_c.delete();
    wr_data_c = 8'h3C; wr_valid_c = 1'b1;
    @(negedge clk); wr_data_c = 8'hFF;
    @(negedge clk); wr_valid_c = 1'b0;
    guard = 0;
    while (busy_c !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
    n_checks++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout busy got %b want 0", busy_c); end
    repeat (3) @(negedge clk);
    decode(2, 1, 8, 2, 0);
    n_checks++; if (rx_words.size() !== 2 || rx_bad !== 0) begin n_fail++; $display("FAIL b2b_frames got %0d bad=%0d want 2 bad=0", rx_words.size(), rx_bad); end
    if (rx_words.size() == 2) begin
      n_checks++; if (rx_words[0] !== 8'h3C || rx_words[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_words got %0h %0h want 3c ff", rx_words[0], rx_words[1]); end
      n_checks++; if (rx_starts[1] - rx_starts[0] !== 11) begin n_fail++; $display("FAIL b2b_spacing got %0d want 11", rx_starts[1] - rx_starts[0]); end
      highs = 0;
      for (int i = rx_starts[0] + 9; i < rx_starts[1]; i++) if (trace_c[i] === 1'b1) highs++;
      n_checks++; if (highs !== 2) begin n_fail++; $display("FAIL b2b_gap got %0d high cycles want 2", highs); end
    end
  endtask

  task automatic test_random_stream();
    int   sb[$];
    int   d, gap, guard;
    trace_c.delete();
    for (int w = 0; w < 12; w++) begin
      d = $urandom_range(0, 255);
      gap = $urandom_range(0, 15);
      repeat (gap) @(negedge clk);
      wr_data_c = 8'(d); wr_valid_c = 1'b1;
      guard = 0;
      while (wr_ready_c !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
      n_checks++; if (wr_ready_c !== 1'b1) begin n_fail++; $display("FAIL rand_ready_timeout got %b want 1", wr_ready_c); end
      else sb.push_back(d);
      @(negedge clk);
      wr_valid_c = 1'b0;
    end
    guard = 0;
    while (busy_c !== 1'b0 && guard < 400) begin @(negedge clk); guard++; end
    n_checks++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL rand_timeout busy got %b want 0", busy_c); end
    repeat (3) @(negedge clk);
    decode(2, 1, 8, 2, 0);
    n_checks++; if (rx_words.size() !== sb.size() || rx_bad !== 0) begin n_fail++; $display("FAIL rand_frames got %0d bad=%0d want %0d bad=0", rx_words.size(), rx_bad, sb.size()); end
    for (int k = 0; k < rx_words.size() && k < sb.size(); k++) begin
      n_checks++; if (rx_words[k] !== sb[k]) begin n_fail++; $display("FAIL rand_word %0d got %0h want %0h", k, rx_words[k], sb[k]); end
      if (k > 0) begin
        n_checks++; if (rx_starts[k] - rx_starts[k-1] < 11) begin n_fail++; $display("FAIL rand_spacing %0d got %0d want >=11", k, rx_starts[k] - rx_starts[k-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_full();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_width_wrap();
    test_back_to_back();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with an integrated transmit FIFO. It replaces the fixed 8N1 transmit path in the core's UART.
- Serial timing comes from an internal baud divider, in the same role as UART_CE, with CLK_DIV = 1 allowed for fast simulation.
- Frame format is generalised: data width, stop-bit count and FIFO depth are all parameters.
- Sits between the CPU store path (or any byte producer) and the txd pin.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4: FIFO entries; power of two, at least 2.
- CLK_DIV, 868: clk cycles per serial bit; at least 1.
- STOP_BITS, 1: stop bits per frame; 1 or 2.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous active-low reset.
- wr_data, input, DATA_BITS: word to transmit.
- wr_valid, input, 1: producer offers wr_data.
- wr_ready, output, 1: FIFO not full.
- txd, output, 1: serial line; idles high.
- busy, output, 1: a frame is in progress, or the FIFO is non-empty.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.
- overflow, output, 1: sticky flag; set when wr_valid is asserted while wr_ready is low.

Behaviour:
- Reset values (reset low, asynchronous): txd=1, wr_ready=1, busy=0, fifo_count=0, overflow=0; FIFO pointers 0; FSM=IDLE; baud counter 0.
  - Reset asserted mid-frame aborts the frame immediately; txd goes high without waiting for a clock edge.
- FIFO write:
  - A word is accepted at the rising edge when wr_valid && wr_ready.
  - wr_ready = (fifo_count != FIFO_DEPTH), purely combinational.
  - When full, a write is rejected even if a pop occurs in the same cycle. No write-through.
- FIFO read:
  - Pop happens only in IDLE with fifo_count != 0.
  - A same-cycle push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A word written into an empty FIFO is visible at fifo_count on the next cycle and can be popped one cycle after its write.
- Baud counter:
  - Loads CLK_DIV-1 on entry to every bit, then decrements each clk.
  - bit_end = (counter == 0). Each bit therefore lasts exactly CLK_DIV cycles.
- FSM, with txd registered:
  - IDLE: txd=1. If the FIFO is non-empty: pop into the shift register, load the counter, go to START. txd drops at that same edge.
  - START: txd=0. On bit_end, go to DATA with bit index 0.
  - DATA: txd = shift[0], LSB first. On bit_end, shift right and increment the index. After DATA_BITS bits, go to PARITY if the parity feature is compiled in, otherwise to STOP.
  - PARITY (feature only): txd = parity bit. On bit_end, go to STOP.
  - STOP: txd=1 for STOP_BITS × CLK_DIV cycles, then return to IDLE.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × CLK_DIV cycles, where P = 1 if parity is compiled in, else 0.
- Back-to-back frames:
  - The IDLE cycle between frames is the last stop cycle. From the end of STOP, IDLE pops and starts the next frame in the same cycle.
  - There is no extra idle gap beyond the stop bits.
- busy = (state != IDLE) || (fifo_count != 0).
- overflow stays set until reset. The rejected word is dropped.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - Adds input port parity_odd (1 bit), sampled at pop and held for the whole frame.
  - The PARITY state transmits the XOR of the data bits; inverted when parity_odd=1 (odd parity).
- When undefined:
  - No parity_odd port and no PARITY state.
  - The frame is start + data + stop only.

Test Plan:
- Single frame, DATA_BITS=8, CLK_DIV=4, STOP_BITS=1, no parity. Write 0xA5 once.
  - txd = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
  - Total 40 cycles from txd falling edge to IDLE; busy deasserts on the next cycle.
- Fill/full, FIFO_DEPTH=4. Write 6 words 0x01..0x06 on consecutive cycles.
  - 0x01 is popped one cycle after its write; 0x02..0x05 fill the FIFO.
  - wr_ready goes low with fifo_count=4; the 0x06 attempt sets overflow=1.
  - Serial output is 0x01..0x05 in order.
- Back-to-back with STOP_BITS=2, CLK_DIV=1. Send 0x3C, 0xFF.
  - Exactly 2 high cycles separate the frames.
  - Second start bit begins at cycle 11 after the first start bit.
- Width and wrap, DATA_BITS=5, FIFO_DEPTH=2. Stream 10 words 0x00..0x09 while keeping the FIFO non-empty.
  - All 10 words are received correctly, exercising pointer wrap.
  - Each frame is 7 bit-times.
- Reset mid-frame. Assert reset during DATA bit 3 of 0x55 with 2 words queued.
  - txd=1 immediately, fifo_count=0, overflow=0, wr_ready=1.
  - After release, txd stays high with no residual frame.
- Parity (UART_TX_PARITY_EN defined), DATA_BITS=8, CLK_DIV=4. Send 0x07 with parity_odd=0, then 0x07 with parity_odd=1.
  - Parity bit = 1, then 0.
  - Frames are 44 cycles each.
